cache_flush_walker: RTL and testbench
=====================================

Name: cache_flush_walker

Overview:
- Per-line valid/dirty state store for the write-back data cache, plus a flush sequencer that drains it.
- On a flush request it walks every line index. For each valid+dirty line it issues one writeback request to the memory-side controller over a valid/ready handshake. Each line is invalidated once it has been handled.
- Sits between the cache tag/data pipeline, which sets bits and reads state, and the writeback path, which consumes WB_* requests.

Parameters:
- depth, 512, number of cache lines; must be a power of two, minimum 2.
- address_width, $clog2(depth), line index width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately.
- SET_VALID  input  1  set valid bit of line WADDR.
- SET_DIRTY  input  1  set dirty bit of line WADDR.
- WADDR  input  address_width  line index for SET_*.
- RADDR  input  address_width  line index for lookup.
- VALID  output  1  valid bit of line RADDR (combinational).
- DIRTY  output  1  dirty bit of line RADDR (combinational).
- FLUSH_REQ  input  1  start flush; sampled only in IDLE.
- BUSY  output  1  high whenever FSM is not IDLE.
- WB_VALID  output  1  writeback request valid.
- WB_ADDR  output  address_width  line index of the writeback request.
- WB_READY  input  1  writeback consumer accepts the request.
- FLUSH_DONE  output  1  one-cycle pulse when the walk completes.

Behaviour:
- Reset (RST=0): all valid and dirty bits = 0; FSM = IDLE; walk index = 0; BUSY = 0; WB_VALID = 0; WB_ADDR = 0; FLUSH_DONE = 0.
- Storage:
  - SET_VALID / SET_DIRTY take effect at the next edge, in IDLE only. Both may assert in the same cycle.
  - SET_DIRTY does not imply valid.
  - While BUSY, SET_* are ignored (dropped); the pipeline is stalled by BUSY.
- Lookup: VALID/DIRTY reflect current stored bits, including during a walk. A write is visible on the cycle after its edge.
- FSM states: IDLE, SCAN, WB, DONE.
- IDLE:
  - FLUSH_REQ=1 -> SCAN with index = 0.
  - If SET_* and FLUSH_REQ occur in the same cycle, the SET_* is applied and is included in the walk.
- SCAN (one cycle per line), examines line[index]:
  - valid and dirty: -> WB; WB_VALID=1 and WB_ADDR=index registered for the next cycle; index unchanged.
  - otherwise: clear valid and dirty of line[index]. If index==depth-1 -> DONE; else index+1 and stay in SCAN.
- WB:
  - Hold WB_VALID=1 and WB_ADDR stable until WB_READY=1. WB_VALID never drops without a handshake.
  - On handshake edge: WB_VALID=0; clear valid and dirty of line[index]. If index==depth-1 -> DONE; else index+1 -> SCAN.
  - WB_READY in any other state is ignored.
- DONE: FLUSH_DONE=1 for exactly one cycle; BUSY still 1; -> IDLE. Index returns to 0.
- FLUSH_REQ outside IDLE is ignored; a new flush needs a fresh request in IDLE.
- Timing:
  - All-clean walk, FLUSH_REQ sampled at edge 0: BUSY high cycles 1..depth+1; FLUSH_DONE in cycle depth+1; BUSY low from cycle depth+2.
  - Each dirty line adds 1 + (WB_READY wait) cycles.
- Index arithmetic is address_width wide. Termination is detected by index==depth-1, not by wrap-around.
- Reset asserted mid-walk aborts immediately: WB_VALID drops asynchronously, all bits are cleared, and FLUSH_DONE is not issued.

Optional Feature:
- Macro: CACHE_FLUSH_WB_COUNT_EN.
- Defined:
  - Adds output WB_COUNT [address_width:0].
  - Cleared to 0 on reset and on the FLUSH_REQ acceptance edge.
  - Increments on each WB handshake.
  - Holds its value after DONE until the next flush.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- depth=8, no lines set, FLUSH_REQ pulse -> BUSY high 9 cycles, FLUSH_DONE single pulse in 9th, WB_VALID never asserted, WB_COUNT=0.
- Set valid on lines 1,3,6; set dirty on 3 and 6; WB_READY tied 1; flush -> exactly two requests, WB_ADDR=3 then 6, each one cycle. Afterwards VALID=0 for all RADDR. WB_COUNT=2.
- Line 5 valid+dirty; WB_READY held 0 for 4 cycles then 1 -> WB_VALID high 5 cycles with WB_ADDR=5 stable; walk resumes at 6 the cycle after handshake.
- During BUSY, pulse SET_VALID/SET_DIRTY on line 2 and FLUSH_REQ -> ignored; after DONE line 2 reads VALID=0, DIRTY=0; no second walk starts.
- Line 7 (last) dirty -> handshake on 7 leads directly to DONE; FLUSH_DONE pulses next cycle; index back to 0.
- Assert RST low while WB_VALID=1 on line 4 -> WB_VALID and BUSY drop without waiting for CLK; all bits read 0 after release; no FLUSH_DONE.

Source files
------------

// File: rtl/cache_flush_walker_if.sv
// Cache-pipeline and writeback-path signals of cache_flush_walker.
// WB_COUNT exists only when CACHE_FLUSH_WB_COUNT_EN is defined.
interface cache_flush_walker_if #(
    parameter int address_width = 9
);
    logic                     SET_VALID;
    logic                     SET_DIRTY;
    logic [address_width-1:0] WADDR;
    logic [address_width-1:0] RADDR;
    logic                     VALID;
    logic                     DIRTY;
    logic                     FLUSH_REQ;
    logic                     BUSY;
    logic                     WB_VALID;
    logic [address_width-1:0] WB_ADDR;
    logic                     WB_READY;
    logic                     FLUSH_DONE;
`ifdef CACHE_FLUSH_WB_COUNT_EN
    logic [address_width:0]   WB_COUNT;
`endif

    modport master (
`ifdef CACHE_FLUSH_WB_COUNT_EN
        input  WB_COUNT,
`endif
        output SET_VALID, SET_DIRTY, WADDR, RADDR, FLUSH_REQ, WB_READY,
        input  VALID, DIRTY, BUSY, WB_VALID, WB_ADDR, FLUSH_DONE
    );

    modport slave (
`ifdef CACHE_FLUSH_WB_COUNT_EN
        output WB_COUNT,
`endif
        input  SET_VALID, SET_DIRTY, WADDR, RADDR, FLUSH_REQ, WB_READY,
        output VALID, DIRTY, BUSY, WB_VALID, WB_ADDR, FLUSH_DONE
    );
endinterface

// File: rtl/cache_flush_walker.sv
// Per-line valid/dirty store with a flush walker that writes back dirty lines.
// Optional writeback counter enabled by defining CACHE_FLUSH_WB_COUNT_EN.
module cache_flush_walker #(
    parameter int depth         = 512,
    parameter int address_width = $clog2(depth)
) (
    input  logic                 CLK,
    input  logic                 RST,
    cache_flush_walker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

    localparam logic [address_width-1:0] LAST = address_width'(depth - 1);

    state_t                   state;
    logic [address_width-1:0] index;
    logic [depth-1:0]         valid_bits;
    logic [depth-1:0]         dirty_bits;
    logic                     wb_valid;
    logic [address_width-1:0] wb_addr;
    logic                     flush_done;

    assign bus.VALID      = valid_bits[bus.RADDR];
    assign bus.DIRTY      = dirty_bits[bus.RADDR];
    assign bus.BUSY       = (state != IDLE);
    assign bus.WB_VALID   = wb_valid;
    assign bus.WB_ADDR    = wb_addr;
    assign bus.FLUSH_DONE = flush_done;

`ifdef CACHE_FLUSH_WB_COUNT_EN
    logic [address_width:0] wb_count;
    assign bus.WB_COUNT = wb_count;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            index      <= '0;
            valid_bits <= '0;
            dirty_bits <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            flush_done <= 1'b0;
`ifdef CACHE_FLUSH_WB_COUNT_EN
            wb_count   <= '0;
`endif
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Writes coinciding with FLUSH_REQ land before the walk reaches any line.
                    if (bus.SET_VALID) valid_bits[bus.WADDR] <= 1'b1;
                    if (bus.SET_DIRTY) dirty_bits[bus.WADDR] <= 1'b1;
                    index <= '0;
                    if (bus.FLUSH_REQ) begin
                        state <= SCAN;
`ifdef CACHE_FLUSH_WB_COUNT_EN
                        wb_count <= '0;
`endif
                    end
                end
                SCAN: begin
                    if (valid_bits[index] && dirty_bits[index]) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                        wb_addr  <= index;
                    end else begin
                        valid_bits[index] <= 1'b0;
                        dirty_bits[index] <= 1'b0;
                        if (index == LAST) begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                WB: begin
                    if (bus.WB_READY) begin
                        wb_valid          <= 1'b0;
                        valid_bits[index] <= 1'b0;
                        dirty_bits[index] <= 1'b0;
`ifdef CACHE_FLUSH_WB_COUNT_EN
                        wb_count <= wb_count + 1'b1;
`endif
                        if (index == LAST) begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end else begin
                            state <= SCAN;
                            index <= index + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    index <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_flush_walker.sv
// Directed bench for cache_flush_walker at depth 8; expected values are hand-computed.
module tb_cache_flush_walker;
    logic CLK;
    logic RST;
    int   tests;
    int   fails;

    int         busy_n, done_n, done_at, wbv_n, hs_n;
    bit         addr_ok;
    logic [2:0] hs_addr [4];

    cache_flush_walker_if #(.address_width(3)) bus ();

    cache_flush_walker #(.depth(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_line(input logic [2:0] a, input logic v, input logic d);
        bus.WADDR     = a;
        bus.SET_VALID = v;
        bus.SET_DIRTY = d;
        tick();
        bus.SET_VALID = 1'b0;
        bus.SET_DIRTY = 1'b0;
    endtask

    task automatic check_all_clear(input string tag);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.RADDR = 3'(i);
            #1;
            if (bus.VALID !== 1'b0 || bus.DIRTY !== 1'b0) ok = 1'b0;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    // Pulses FLUSH_REQ and follows the walk until BUSY drops, recording what it saw.
    // stall: cycles WB_READY stays low per request; with_set: set line 0 v+d with the request;
    // inject: fire SET on line 2 plus FLUSH_REQ in cycle 5 of the walk.
    task automatic do_flush(input int stall, input bit with_set, input bit inject);
        int         c;
        int         wait_n;
        bit         pend;
        logic [2:0] last_addr;
        busy_n = 0; done_n = 0; done_at = 0; wbv_n = 0; hs_n = 0;
        addr_ok = 1'b1; wait_n = 0; pend = 1'b0; last_addr = '0;
        bus.FLUSH_REQ = 1'b1;
        if (with_set) begin
            bus.WADDR = 3'd0; bus.SET_VALID = 1'b1; bus.SET_DIRTY = 1'b1;
        end
        tick();
        bus.FLUSH_REQ = 1'b0; bus.SET_VALID = 1'b0; bus.SET_DIRTY = 1'b0;
        c = 1;
        while (bus.BUSY && c < 100) begin
            busy_n++;
            if (bus.FLUSH_DONE) begin done_n++; done_at = c; end
            if (bus.WB_VALID) begin
                wbv_n++;
                if (pend && bus.WB_ADDR !== last_addr) addr_ok = 1'b0;
                last_addr    = bus.WB_ADDR;
                bus.WB_READY = (wait_n >= stall);
                if (bus.WB_READY) begin
                    if (hs_n < 4) hs_addr[hs_n] = bus.WB_ADDR;
                    hs_n++; wait_n = 0; pend = 1'b0;
                end else begin
                    wait_n++; pend = 1'b1;
                end
            end else begin
                if (pend) addr_ok = 1'b0;
                bus.WB_READY = 1'b0;
                pend = 1'b0;
            end
            if (inject && c == 5) begin
                bus.WADDR = 3'd2; bus.SET_VALID = 1'b1; bus.SET_DIRTY = 1'b1;
                bus.FLUSH_REQ = 1'b1;
            end else begin
                bus.SET_VALID = 1'b0; bus.SET_DIRTY = 1'b0; bus.FLUSH_REQ = 1'b0;
            end
            tick();
            c++;
        end
        bus.WB_READY = 1'b0; bus.FLUSH_REQ = 1'b0;
        bus.SET_VALID = 1'b0; bus.SET_DIRTY = 1'b0;
        chk("walk_terminates", 32'(bus.BUSY), 32'd0);
        chk("done_low_after_walk", 32'(bus.FLUSH_DONE), 32'd0);
    endtask

    initial begin
        int k;
        tests = 0; fails = 0;
        RST = 1'b0;
        bus.SET_VALID = 1'b0; bus.SET_DIRTY = 1'b0; bus.WADDR = '0; bus.RADDR = '0;
        bus.FLUSH_REQ = 1'b0; bus.WB_READY = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_wb_valid", 32'(bus.WB_VALID), 32'd0);
        chk("rst_wb_addr", 32'(bus.WB_ADDR), 32'd0);
        chk("rst_flush_done", 32'(bus.FLUSH_DONE), 32'd0);
        RST = 1'b1;
        tick();
        check_all_clear("rst_lines_clear");

        // All-clean walk: 9 busy cycles, done in the 9th, no writebacks.
        do_flush(0, 1'b0, 1'b0);
        chk("clean_busy_cycles", 32'(busy_n), 32'd9);
        chk("clean_done_count", 32'(done_n), 32'd1);
        chk("clean_done_cycle", 32'(done_at), 32'd9);
        chk("clean_wb_valid_cycles", 32'(wbv_n), 32'd0);
`ifdef CACHE_FLUSH_WB_COUNT_EN
        chk("clean_wb_count", 32'(bus.WB_COUNT), 32'd0);
`endif

        // Lines 1 (valid), 2 (dirty only), 3 and 6 (valid+dirty).
        set_line(3'd1, 1'b1, 1'b0);
        set_line(3'd2, 1'b0, 1'b1);
        set_line(3'd3, 1'b1, 1'b1);
        set_line(3'd6, 1'b1, 1'b1);
        bus.RADDR = 3'd1; #1;
        chk("lookup1_valid", 32'(bus.VALID), 32'd1);
        chk("lookup1_dirty", 32'(bus.DIRTY), 32'd0);
        bus.RADDR = 3'd2; #1;
        chk("dirty_no_valid_v", 32'(bus.VALID), 32'd0);
        chk("dirty_no_valid_d", 32'(bus.DIRTY), 32'd1);
        bus.RADDR = 3'd3; #1;
        chk("lookup3_dirty", 32'(bus.DIRTY), 32'd1);
        do_flush(0, 1'b0, 1'b0);
        chk("two_wb_handshakes", 32'(hs_n), 32'd2);
        chk("two_wb_first_addr", 32'(hs_addr[0]), 32'd3);
        chk("two_wb_second_addr", 32'(hs_addr[1]), 32'd6);
        chk("two_wb_valid_cycles", 32'(wbv_n), 32'd2);
        chk("two_wb_busy_cycles", 32'(busy_n), 32'd11);
        chk("two_wb_done_cycle", 32'(done_at), 32'd11);
        check_all_clear("two_wb_lines_clear");
`ifdef CACHE_FLUSH_WB_COUNT_EN
        chk("two_wb_count", 32'(bus.WB_COUNT), 32'd2);
`endif

        // Line 5 dirty with four stall cycles.
        set_line(3'd5, 1'b1, 1'b1);
        do_flush(4, 1'b0, 1'b0);
        chk("stall_wb_valid_cycles", 32'(wbv_n), 32'd5);
        chk("stall_handshakes", 32'(hs_n), 32'd1);
        chk("stall_addr", 32'(hs_addr[0]), 32'd5);
        chk("stall_addr_stable", 32'(addr_ok), 32'd1);
        chk("stall_busy_cycles", 32'(busy_n), 32'd14);
        chk("stall_done_cycle", 32'(done_at), 32'd14);
`ifdef CACHE_FLUSH_WB_COUNT_EN
        chk("stall_wb_count", 32'(bus.WB_COUNT), 32'd1);
`endif

        // SET_* and FLUSH_REQ during the walk are dropped.
        do_flush(0, 1'b0, 1'b1);
        chk("busy_ignore_busy_cycles", 32'(busy_n), 32'd9);
        chk("busy_ignore_handshakes", 32'(hs_n), 32'd0);
        bus.RADDR = 3'd2; #1;
        chk("busy_ignore_valid", 32'(bus.VALID), 32'd0);
        chk("busy_ignore_dirty", 32'(bus.DIRTY), 32'd0);
        tick(); tick();
        chk("busy_ignore_no_rewalk", 32'(bus.BUSY), 32'd0);

        // Last line dirty: handshake goes straight to DONE.
        set_line(3'd7, 1'b1, 1'b1);
        do_flush(0, 1'b0, 1'b0);
        chk("last_line_addr", 32'(hs_addr[0]), 32'd7);
        chk("last_line_busy_cycles", 32'(busy_n), 32'd10);
        chk("last_line_done_cycle", 32'(done_at), 32'd10);

        // Line 0 set together with FLUSH_REQ is included; also proves the index restarted at 0.
        do_flush(0, 1'b1, 1'b0);
        chk("set_with_req_handshakes", 32'(hs_n), 32'd1);
        chk("set_with_req_addr", 32'(hs_addr[0]), 32'd0);
        chk("set_with_req_busy_cycles", 32'(busy_n), 32'd10);
        check_all_clear("set_with_req_clear");

        // Reset while a writeback on line 4 is outstanding.
        set_line(3'd4, 1'b1, 1'b1);
        set_line(3'd1, 1'b1, 1'b0);
        bus.FLUSH_REQ = 1'b1;
        tick();
        bus.FLUSH_REQ = 1'b0;
        k = 0;
        while (!bus.WB_VALID && k < 20) begin
            tick();
            k++;
        end
        chk("rst_mid_wb_seen", 32'(bus.WB_VALID), 32'd1);
        chk("rst_mid_wb_addr", 32'(bus.WB_ADDR), 32'd4);
        #2;
        RST = 1'b0;
        #1;
        chk("rst_mid_wb_valid_async", 32'(bus.WB_VALID), 32'd0);
        chk("rst_mid_busy_async", 32'(bus.BUSY), 32'd0);
        tick();
        chk("rst_mid_no_done_a", 32'(bus.FLUSH_DONE), 32'd0);
        RST = 1'b1;
        tick();
        chk("rst_mid_no_done_b", 32'(bus.FLUSH_DONE), 32'd0);
        chk("rst_mid_idle", 32'(bus.BUSY), 32'd0);
        check_all_clear("rst_mid_lines_clear");
`ifdef CACHE_FLUSH_WB_COUNT_EN
        chk("rst_mid_wb_count", 32'(bus.WB_COUNT), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
